// File: rtl/hack_pkg.sv
// Shared Hack ALU definitions: word type, control bundle layout and the
// eighteen comp encodings used by the CPU decoder and the test bench.
package hack_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    // Bit order matches the Hack comp field: zx is the MSB, no the LSB.
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    localparam int ALU_CTRL_W = $bits(alu_ctrl_t);

    // Hack comp encodings; x is the D register, y is A or M.
    localparam alu_ctrl_t ALU_ZERO      = 6'b101010;
    localparam alu_ctrl_t ALU_ONE       = 6'b111111;
    localparam alu_ctrl_t ALU_NEG1      = 6'b111010;
    localparam alu_ctrl_t ALU_X         = 6'b001100;
    localparam alu_ctrl_t ALU_Y         = 6'b110000;
    localparam alu_ctrl_t ALU_NOT_X     = 6'b001101;
    localparam alu_ctrl_t ALU_NOT_Y     = 6'b110001;
    localparam alu_ctrl_t ALU_NEG_X     = 6'b001111;
    localparam alu_ctrl_t ALU_NEG_Y     = 6'b110011;
    localparam alu_ctrl_t ALU_X_PLUS_1  = 6'b011111;
    localparam alu_ctrl_t ALU_Y_PLUS_1  = 6'b110111;
    localparam alu_ctrl_t ALU_X_MINUS_1 = 6'b001110;
    localparam alu_ctrl_t ALU_Y_MINUS_1 = 6'b110010;
    localparam alu_ctrl_t ALU_X_PLUS_Y  = 6'b000010;
    localparam alu_ctrl_t ALU_X_MINUS_Y = 6'b010011;
    localparam alu_ctrl_t ALU_Y_MINUS_X = 6'b000111;
    localparam alu_ctrl_t ALU_X_AND_Y   = 6'b000000;
    localparam alu_ctrl_t ALU_X_OR_Y    = 6'b010101;

    // True when a control bundle is one of the eighteen defined comp codes.
    function automatic logic is_hack_comp(input alu_ctrl_t c);
        logic hit;
        hit = 1'b0;
        case (c)
            ALU_ZERO, ALU_ONE, ALU_NEG1, ALU_X, ALU_Y,
            ALU_NOT_X, ALU_NOT_Y, ALU_NEG_X, ALU_NEG_Y,
            ALU_X_PLUS_1, ALU_Y_PLUS_1, ALU_X_MINUS_1, ALU_Y_MINUS_1,
            ALU_X_PLUS_Y, ALU_X_MINUS_Y, ALU_Y_MINUS_X,
            ALU_X_AND_Y, ALU_X_OR_Y: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/hack_alu_core.sv
// Combinational second half of the Hack ALU: add or AND the already
// pre-processed operands, optionally invert, and derive the flags from the
// final (post-invert) value.
module hack_alu_core
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH-1:0] xp,
    input  logic [WIDTH-1:0] yp,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] res,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] conj;
    logic [WIDTH-1:0] r;

    // Compute result and flags; the adder carry out of the MSB is dropped.
    always_comb begin
        sum  = xp + yp;
        conj = xp & yp;
        r    = f ? sum : conj;
        res  = no ? ~r : r;
        zr   = (res == '0);
        ng   = res[WIDTH-1];
    end

endmodule

// File: rtl/hack_alu_stage.sv
// Two-stage registered Hack ALU with valid/ready flow control on both sides.
// S1 holds the zeroed/inverted operands, S2 holds the final result and flags.
//
// Handshake: a bundle moves in when in_valid && in_ready and moves out when
// out_valid && out_ready. Each stage advances when it is empty or the stage
// after it advances, so in_ready depends combinationally on out_ready; the
// integrator must not make out_ready depend on in_ready. out/zr/ng stay
// constant while out_valid is high and out_ready is low.
module hack_alu_stage
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    alu_ctrl_t        ctrl_in;
    logic [WIDTH-1:0] x_z;
    logic [WIDTH-1:0] y_z;
    logic [WIDTH-1:0] xp_d;
    logic [WIDTH-1:0] yp_d;

    // S1 state
    logic [WIDTH-1:0] xp_q;
    logic [WIDTH-1:0] yp_q;
    logic             f_q;
    logic             no_q;
    logic             v1;

    // S2 state
    logic [WIDTH-1:0] out_q;
    logic             zr_q;
    logic             ng_q;
    logic             v2;

    // Core outputs feeding S2
    logic [WIDTH-1:0] res_d;
    logic             zr_d;
    logic             ng_d;

    logic s1_en;
    logic s2_en;

    assign ctrl_in = {zx, nx, zy, ny, f, no};

    // Stage enables: a stage may load when it is empty or its contents leave.
    always_comb begin
        s2_en    = !v2 || out_ready;
        s1_en    = !v1 || s2_en;
        in_ready = s1_en;
    end

    // Operand pre-processing: zero first, then invert.
    always_comb begin
        x_z  = ctrl_in.zx ? '0 : x;
        y_z  = ctrl_in.zy ? '0 : y;
        xp_d = ctrl_in.nx ? ~x_z : x_z;
        yp_d = ctrl_in.ny ? ~y_z : y_z;
    end

    // S1 register: captures the pre-processed bundle when allowed to advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            xp_q <= '0;
            yp_q <= '0;
            f_q  <= 1'b0;
            no_q <= 1'b0;
            v1   <= 1'b0;
        end else if (s1_en) begin
            xp_q <= xp_d;
            yp_q <= yp_d;
            f_q  <= ctrl_in.f;
            no_q <= ctrl_in.no;
            v1   <= in_valid;
        end
    end

    hack_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .xp  (xp_q),
        .yp  (yp_q),
        .f   (f_q),
        .no  (no_q),
        .res (res_d),
        .zr  (zr_d),
        .ng  (ng_d)
    );

    // S2 register: result and flags; reset value describes a zero word.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            zr_q  <= 1'b1;
            ng_q  <= 1'b0;
            v2    <= 1'b0;
        end else if (s2_en) begin
            out_q <= res_d;
            zr_q  <= zr_d;
            ng_q  <= ng_d;
            v2    <= v1;
        end
    end

    assign out_valid = v2;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;

endmodule

// File: tb/tb_hack_alu_stage.sv
// Bench for hack_alu_stage: directed vectors with literal expectations, an
// arithmetic reference model with an in-order expected queue, and a random
// flow-control phase.
module tb_hack_alu_stage;
    import hack_pkg::*;

    typedef struct packed {
        word_t out;
        logic  zr;
        logic  ng;
    } res_t;

    logic  clk;
    logic  reset;
    logic  in_valid;
    logic  in_ready;
    word_t x;
    word_t y;
    logic  zx, nx, zy, ny, f, no;
    logic  out_valid;
    logic  out_ready;
    word_t out;
    logic  zr;
    logic  ng;

    int n_checks;
    int n_fail;

    res_t exp_q[$];
    res_t lit_q[$];

    hack_alu_stage #(
        .WIDTH (WORD_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .zx        (zx),
        .nx        (nx),
        .zy        (zy),
        .ny        (ny),
        .f         (f),
        .no        (no),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zr        (zr),
        .ng        (ng)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in plain unsigned arithmetic on the value 0..2^W-1.
    function automatic res_t alu_model(input word_t a, input word_t b, input alu_ctrl_t c);
        int unsigned m;
        int unsigned xa;
        int unsigned ya;
        int unsigned r;
        res_t        o;
        m  = (1 << WORD_W) - 1;
        xa = c.zx ? 0 : int'(a);
        ya = c.zy ? 0 : int'(b);
        if (c.nx) xa = m - xa;
        if (c.ny) ya = m - ya;
        if (c.f) r = (xa + ya) % (m + 1);
        else     r = xa & ya;
        if (c.no) r = m - r;
        o.out = word_t'(r);
        o.zr  = (r == 0);
        o.ng  = (r >= (1 << (WORD_W - 1)));
        return o;
    endfunction

    function automatic res_t mk(input word_t o, input logic z, input logic n);
        res_t r;
        r.out = o;
        r.zr  = z;
        r.ng  = n;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: checks every valid output cycle against model and literals.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            lit_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    check("model_out", 32'(out), 32'(exp_q[0].out));
                    check("model_zr", 32'(zr), 32'(exp_q[0].zr));
                    check("model_ng", 32'(ng), 32'(exp_q[0].ng));
                    if (lit_q.size() > 0) begin
                        check("lit_out", 32'(out), 32'(lit_q[0].out));
                        check("lit_flags", 32'({zr, ng}), 32'({lit_q[0].zr, lit_q[0].ng}));
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (lit_q.size() > 0) void'(lit_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(alu_model(x, y, {zx, nx, zy, ny, f, no}));
                check("capacity", 32'(exp_q.size() <= 2), 32'd1);
            end
        end
    end

    // Offer one bundle and hold it until accepted (bounded); called at posedge+1.
    task automatic put(input word_t a, input word_t b, input alu_ctrl_t c,
                       input res_t lit, input bit must);
        int budget;
        lit_q.push_back(lit);
        x = a;
        y = b;
        {zx, nx, zy, ny, f, no} = c;
        in_valid = 1'b1;
        @(negedge clk);
        if (must) check("no_bubble", 32'(in_ready), 32'd1);
        budget = 0;
        while (!in_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            void'(lit_q.pop_back());
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for all expected results to retire; returns at posedge+1.
    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 100) begin
            @(negedge clk);
            b++;
        end
        @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("lit_empty", 32'(lit_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        res_t m;
        int   acc;
        int   cyc;

        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x = '0;
        y = '0;
        {zx, nx, zy, ny, f, no} = 6'b0;

        // Pin the model with hand-computed values
        m = alu_model(16'd5, 16'd3, ALU_X_PLUS_Y);
        check("pin_add", 32'(m), 32'(mk(16'h0008, 1'b0, 1'b0)));
        m = alu_model(16'd3, 16'd5, ALU_X_MINUS_Y);
        check("pin_sub", 32'(m), 32'(mk(16'hFFFE, 1'b0, 1'b1)));
        m = alu_model(16'h1234, 16'hABCD, ALU_ZERO);
        check("pin_zero", 32'(m), 32'(mk(16'h0000, 1'b1, 1'b0)));
        m = alu_model(16'h00F0, 16'h0F00, ALU_X_OR_Y);
        check("pin_or", 32'(m), 32'(mk(16'h0FF0, 1'b0, 1'b0)));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_zr", 32'(zr), 32'd1);
        check("rst_ng", 32'(ng), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Add: result two cycles after acceptance, valid for exactly one cycle
        put(16'd5, 16'd3, ALU_X_PLUS_Y, mk(16'h0008, 1'b0, 1'b0), 1'b1);
        @(negedge clk);
        check("add_lat_n1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("add_lat_n2", 32'(out_valid), 32'd1);
        check("add_out", 32'(out), 32'h0008);
        @(negedge clk);
        check("add_one_cycle", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Subtract both ways, back to back
        put(16'd5, 16'd3, ALU_X_MINUS_Y, mk(16'h0002, 1'b0, 1'b0), 1'b1);
        put(16'd5, 16'd3, ALU_Y_MINUS_X, mk(16'hFFFE, 1'b0, 1'b1), 1'b1);
        @(negedge clk);
        check("sub_first_valid", 32'(out_valid), 32'd1);
        check("sub_first_out", 32'(out), 32'h0002);
        @(negedge clk);
        check("sub_second_valid", 32'(out_valid), 32'd1);
        check("sub_second_out", 32'(out), 32'hFFFE);
        @(posedge clk);
        #1;
        drain();

        // Constants and wrap-around
        put(16'h1234, 16'h5678, ALU_ZERO, mk(16'h0000, 1'b1, 1'b0), 1'b1);
        put(16'h1234, 16'h5678, ALU_NEG1, mk(16'hFFFF, 1'b0, 1'b1), 1'b1);
        put(16'h7FFF, 16'h0001, ALU_X_PLUS_Y, mk(16'h8000, 1'b0, 1'b1), 1'b1);
        put(16'hFFFF, 16'h0001, ALU_X_PLUS_Y, mk(16'h0000, 1'b1, 1'b0), 1'b1);
        put(16'h00F0, 16'h0F00, ALU_ONE, mk(16'h0001, 1'b0, 1'b0), 1'b1);
        drain();

        // Backpressure: A and B fill the pipe, C is held off until release
        out_ready = 1'b0;
        put(16'h00F0, 16'h0F00, ALU_X_OR_Y, mk(16'h0FF0, 1'b0, 1'b0), 1'b1);
        put(16'hFF00, 16'h0FF0, ALU_X_AND_Y, mk(16'h0F00, 1'b0, 1'b0), 1'b1);
        lit_q.push_back(mk(16'h0000, 1'b1, 1'b0));
        x = 16'hFFFF;
        y = 16'h0000;
        {zx, nx, zy, ny, f, no} = ALU_X_PLUS_1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_hold_out", 32'(out), 32'h0FF0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_on_retire", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Random operands, controls and flow control
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            x = word_t'($urandom);
            y = word_t'($urandom);
            {zx, nx, zy, ny, f, no} = 6'($urandom_range(0, 63));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("random_count", 32'(acc), 32'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with two bundles in flight
        out_ready = 1'b0;
        put(16'd7, 16'd9, ALU_X_PLUS_Y, mk(16'h0010, 1'b0, 1'b0), 1'b1);
        put(16'd7, 16'd9, ALU_X_MINUS_Y, mk(16'hFFFE, 1'b0, 1'b1), 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_zr", 32'(zr), 32'd1);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
